// File: rtl/key_debounce.sv
// key_debounce: per-key 2-flop synchroniser, debounce FSM and press/release/toggle outputs.
// Define KEY_DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a key is held.
module key_debounce #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 12500000,
  parameter int unsigned HOLD_W          = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_toggle
);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Synchroniser output is in pressed polarity: 1 = key down.
  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~key_n;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_toggle;
    logic             w_s;
    logic             w_cnt_done;
    logic             w_press_ev;
    logic             w_release_ev;
    logic             w_rep_ev;

    assign w_s        = r_sync2[k];
    assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ST_RELEASED;
      else       r_state <= w_state_nxt;
    end

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_RELEASED:     if (w_s)              w_state_nxt = ST_PRESS_WAIT;
        ST_PRESS_WAIT:   if (!w_s)             w_state_nxt = ST_RELEASED;
                         else if (w_cnt_done)  w_state_nxt = ST_PRESSED;
        ST_PRESSED:      if (!w_s)             w_state_nxt = ST_RELEASE_WAIT;
        ST_RELEASE_WAIT: if (w_s)              w_state_nxt = ST_PRESSED;
                         else if (w_cnt_done)  w_state_nxt = ST_RELEASED;
        default:                               w_state_nxt = ST_RELEASED;
      endcase
    end

    // Counter update and accept events; the counter clears on every transition.
    always_comb begin
      w_cnt_nxt    = r_cnt;
      w_press_ev   = 1'b0;
      w_release_ev = 1'b0;
      case (r_state)
        ST_RELEASED: begin
          if (w_s) w_cnt_nxt = CNT_W'(1);
        end
        ST_PRESS_WAIT: begin
          if (!w_s) begin
            w_cnt_nxt = '0;
          end else if (w_cnt_done) begin
            w_cnt_nxt  = '0;
            w_press_ev = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!w_s) w_cnt_nxt = CNT_W'(1);
        end
        ST_RELEASE_WAIT: begin
          if (w_s) begin
            w_cnt_nxt = '0;
          end else if (w_cnt_done) begin
            w_cnt_nxt    = '0;
            w_release_ev = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: w_cnt_nxt = '0;
      endcase
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_rpt;
    logic              w_rpt_nxt;
    logic [HOLD_W-1:0] w_hold_lim;

    // First repeat waits HOLD_CYCLES, later ones REPEAT_CYCLES.
    assign w_hold_lim = r_rpt ? HOLD_W'(REPEAT_CYCLES - 1) : HOLD_W'(HOLD_CYCLES - 1);

    always_comb begin
      w_hold_nxt = '0;
      w_rpt_nxt  = 1'b0;
      w_rep_ev   = 1'b0;
      if (r_state == ST_PRESSED && w_s) begin
        if (r_hold == w_hold_lim) begin
          w_rep_ev  = 1'b1;
          w_rpt_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
          w_rpt_nxt  = r_rpt;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_hold <= '0;
        r_rpt  <= 1'b0;
      end else begin
        r_hold <= w_hold_nxt;
        r_rpt  <= w_rpt_nxt;
      end
    end
`else
    logic w_unused_cfg;
    assign w_rep_ev     = 1'b0;
    assign w_unused_cfg = ^{HOLD_W'(HOLD_CYCLES), HOLD_W'(REPEAT_CYCLES)};
`endif

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_toggle  <= 1'b0;
      end else begin
        r_cnt     <= w_cnt_nxt;
        r_press   <= w_press_ev | w_rep_ev;
        r_release <= w_release_ev;
        if (w_press_ev) begin
          r_level  <= 1'b1;
          r_toggle <= ~r_toggle;
        end else if (w_release_ev) begin
          r_level <= 1'b0;
        end
      end
    end

    assign key_level[k]   = r_level;
    assign key_press[k]   = r_press;
    assign key_release[k] = r_release;
    assign key_toggle[k]  = r_toggle;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity against a run-length reference model.
module tb_key_debounce;
  localparam int unsigned NK = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned HC = 10;
  localparam int unsigned RC = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_toggle;

  int tests = 0;
  int fails = 0;

  // Reference model: two-sample input history, per-key run lengths, expected outputs.
  logic [NK-1:0] h1, h2;
  logic [NK-1:0] m_level, m_press, m_release, m_toggle;
  int            diff_run [NK];
  int            hold_run [NK];

  key_debounce #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .CNT_W(20),
    .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .HOLD_W(26)
  ) dut (
    .clock(clock), .reset(reset), .key_n(key_n),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_toggle(key_toggle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_level"},   key_level,   m_level);
    chk({tag, "_press"},   key_press,   m_press);
    chk({tag, "_release"}, key_release, m_release);
    chk({tag, "_toggle"},  key_toggle,  m_toggle);
  endtask

  task automatic model_reset();
    h1 = '0; h2 = '0;
    m_level = '0; m_press = '0; m_release = '0; m_toggle = '0;
    for (int k = 0; k < NK; k++) begin
      diff_run[k] = 0;
      hold_run[k] = 0;
    end
  endtask

  // A level flips after DB consecutive samples disagree with it; repeats count agreeing samples while settled-pressed.
  task automatic model_step();
    logic s;
    m_press   = '0;
    m_release = '0;
    for (int k = 0; k < NK; k++) begin
      s = h2[k];
      if (s != m_level[k]) begin
        diff_run[k]++;
        hold_run[k] = 0;
        if (diff_run[k] == DB) begin
          diff_run[k] = 0;
          m_level[k]  = s;
          if (s) begin
            m_press[k]  = 1'b1;
            m_toggle[k] = ~m_toggle[k];
          end else begin
            m_release[k] = 1'b1;
          end
        end
      end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
        if (m_level[k] && diff_run[k] == 0) begin
          hold_run[k]++;
          if (hold_run[k] == HC || (hold_run[k] > HC && (hold_run[k] - HC) % RC == 0))
            m_press[k] = 1'b1;
        end
`endif
        diff_run[k] = 0;
      end
    end
    h2 = h1;
    h1 = ~key_n;
  endtask

  // Called at a negedge; returns at the next negedge after checking the posedge in between.
  task automatic tick(input string tag = "cyc");
    @(posedge clock);
    #1;
    model_step();
    check_all(tag);
    @(negedge clock);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (cycles) begin
      @(posedge clock);
      #1;
      check_all("rst_hold");
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  int unsigned p;
  int          npulse;
  int          ntog;
  logic        tog_prev;

  initial begin
    reset = 1'b1;
    key_n = '1;
    do_reset(2);

    // Idle keys: all outputs stay low.
    repeat (10) tick("idle");

    // Clean press of key 0: accepted at edge DB+2.
    key_n = 4'b1110;
    repeat (DB + 1) tick("k0p");
    chk("k0_level_edge5", key_level, 4'b0000);
    tick("k0p");
    chk("k0_level_edge6",  key_level,  4'b0001);
    chk("k0_press_edge6",  key_press,  4'b0001);
    chk("k0_toggle_edge6", key_toggle, 4'b0001);
    tick("k0p");
    chk("k0_press_edge7", key_press, 4'b0000);
    key_n = 4'b1111;
    repeat (DB + 1) tick("k0r");
    chk("k0_release_edge5", key_release, 4'b0000);
    tick("k0r");
    chk("k0_release_edge6", key_release, 4'b0001);
    chk("k0_level_rel",     key_level,   4'b0000);
    repeat (3) tick("k0r");

    // Bounce on key 1: 3 low, 1 high, 3 low, then high -> ignored.
    key_n = 4'b1101; repeat (3) tick("bnc");
    key_n = 4'b1111; tick("bnc");
    key_n = 4'b1101; repeat (3) tick("bnc");
    key_n = 4'b1111; repeat (6) tick("bnc");
    chk("bnc_level",  key_level,  4'b0000);
    chk("bnc_toggle", key_toggle, 4'b0001);
    key_n = 4'b1101; repeat (DB + 2) tick("k1p");
    chk("k1_level_clean", key_level, 4'b0010);
    key_n = 4'b1111; repeat (DB + 4) tick("k1r");

    // Keys 0 and 3 pressed together.
    key_n = 4'b0110;
    repeat (DB + 2) tick("k03");
    chk("k03_press",  key_press,  4'b1001);
    chk("k03_toggle", key_toggle, 4'b1010);
    key_n = 4'b1111; repeat (DB + 4) tick("k03r");

    // Reset two cycles into press-wait with key 2 held.
    key_n = 4'b1011;
    repeat (4) tick("k2pre");
    do_reset(2);
    repeat (DB + 1) tick("k2post");
    chk("k2_level_before", key_level, 4'b0000);
    tick("k2post");
    chk("k2_level_after", key_level,  4'b0100);
    chk("k2_press_after", key_press,  4'b0100);
    chk("k2_toggle",      key_toggle, 4'b0100);
    key_n = 4'b1111; repeat (DB + 4) tick("k2r");

    // Long hold of key 0: auto-repeat pulses only when enabled, toggle unaffected.
    key_n = 4'b1110;
    repeat (DB + 2) tick("hold");
    npulse = 0;
    ntog = 0;
    tog_prev = key_toggle[0];
    for (int c = 0; c < 30; c++) begin
      tick("hold");
      if (key_press[0]) npulse++;
      if (key_toggle[0] != tog_prev) ntog++;
      tog_prev = key_toggle[0];
    end
`ifdef KEY_DEBOUNCE_REPEAT_EN
    chk_int("repeat_pulses", npulse, 5);
`else
    chk_int("repeat_pulses", npulse, 0);
`endif
    chk_int("repeat_toggle_changes", ntog, 0);
    key_n = 4'b1111; repeat (DB + 4) tick("holdr");

    // Random key activity alternating between bouncy and mostly-steady segments.
    for (int seg = 0; seg < 12; seg++) begin
      p = (seg % 2 == 1) ? 3 : 40;
      for (int c = 0; c < 60; c++) begin
        for (int k = 0; k < NK; k++)
          if ($urandom_range(p - 1, 0) == 0) key_n[k] = ~key_n[k];
        tick("rnd");
      end
    end
    key_n = 4'b1111;
    repeat (DB + 4) tick("end");
    chk("final_level", key_level, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Pushbutton conditioning stage for the DE1 board, directly upstream of the BCD counter and seven-segment path. It synchronises the raw active-low KEY inputs, debounces each key independently with a per-key state machine, and produces clean level, press-pulse, release-pulse and toggle outputs. `key_toggle` drives the counter `enable` and `key_press` provides single-step or clear commands, replacing raw KEY wiring.

## Interface
- `N_KEYS`, 4: number of independent keys.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a change (20 ms at 50 MHz). Must be ≥2 and <2^`CNT_W`.
- `CNT_W`, 20: width of the per-key debounce counter.
- `HOLD_CYCLES`, 50000000: continuous-press time before the first auto-repeat. Used only with the repeat feature.
- `REPEAT_CYCLES`, 12500000: interval between auto-repeats. Used only with the repeat feature.
- `HOLD_W`, 26: width of the per-key hold counter. Must hold `HOLD_CYCLES` and `REPEAT_CYCLES`.

Ports:
- `clock` in 1: single clock, 50 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `key_n` in `N_KEYS`: raw pushbuttons, active-low, asynchronous to `clock`.
- `key_level` out `N_KEYS`: debounced state, 1 = pressed.
- `key_press` out `N_KEYS`: one-cycle pulse on accepted press (and on auto-repeat).
- `key_release` out `N_KEYS`: one-cycle pulse on accepted release.
- `key_toggle` out `N_KEYS`: inverts on each accepted press. Auto-repeats do not affect it.

## Operation
- Per key, a 2-flop synchroniser; its output `s` is 1 when the key is pressed (inverted `key_n`).
- Per-key FSM states:
  - RELEASED: if `s`=1, go to PRESS_WAIT and set cnt=1.
  - PRESS_WAIT:
    - If `s`=0, return to RELEASED and set cnt=0. No output.
    - If `s`=1 and cnt=`DEBOUNCE_CYCLES`-1, go to PRESSED; set `key_level`=1, pulse `key_press`, invert `key_toggle`, set cnt=0.
    - Otherwise increment cnt.
  - PRESSED: if `s`=0, go to RELEASE_WAIT and set cnt=1.
  - RELEASE_WAIT:
    - If `s`=1, return to PRESSED and set cnt=0.
    - If `s`=0 and cnt=`DEBOUNCE_CYCLES`-1, go to RELEASED; set `key_level`=0, pulse `key_release`, set cnt=0.
    - Otherwise increment cnt.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no output change and does not disturb the stable state.
- Keys are fully independent. Several keys may pulse in the same cycle.
- All outputs are registered. Pulses are exactly one cycle wide.
- Reset values:
  - Synchroniser flops: released.
  - FSMs: RELEASED.
  - All counters: 0.
  - `key_level`, `key_press`, `key_release`, `key_toggle`: 0.

## Timing
- A clean edge on `key_n`, first sampled at clock edge 1, causes the output change at edge `DEBOUNCE_CYCLES`+2:
  - 2 edges for synchronisation.
  - `DEBOUNCE_CYCLES` edges of stable `s`, starting at edge 3.
- Press and release latency are identical.
- `key_level` changes on the same edge as its `key_press` or `key_release` pulse.
- If `reset` is asserted mid-debounce or mid-hold, everything clears immediately (asynchronously). A key still held after reset deasserts is accepted as a new press after the full latency.
- Counters never wrap, because they are cleared on every state transition.

## Configuration
- `KEY_DEBOUNCE_REPEAT_EN` defined:
  - While in PRESSED, a per-key hold counter runs.
  - When it reaches `HOLD_CYCLES`, `key_press` pulses and the counter reloads.
  - A further pulse follows every `REPEAT_CYCLES` while the key is still PRESSED.
  - The hold counter clears on leaving PRESSED, including to RELEASE_WAIT, and resumes from 0 if the FSM returns to PRESSED.
  - `key_toggle` and `key_level` are unaffected by repeats.
- `KEY_DEBOUNCE_REPEAT_EN` undefined:
  - No hold counters are instantiated.
  - `key_press` pulses only once per accepted press.
  - `HOLD_CYCLES`, `REPEAT_CYCLES` and `HOLD_W` are ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=5 unless stated otherwise.
- Reset, then hold `key_n`=4'b1111 → all outputs 0 indefinitely.
- Drive `key_n[0]` low at edge 1 and hold → `key_level[0]` and `key_press[0]` rise at edge 6; `key_press[0]` falls at edge 7; `key_toggle[0]`=1. Release → `key_release[0]` pulses 6 edges later.
- Bounce `key_n[1]` low 3 cycles, high 1 cycle, low 3 cycles, then high → no output changes. A subsequent clean 4-cycle-stable low is accepted.
- Press keys 0 and 3 on the same edge → both `key_press` bits pulse on the same cycle. Press key 0 again → `key_toggle[0]` returns to 0 while `key_toggle[3]` stays 1.
- Assert `reset` 2 cycles into PRESS_WAIT, with the key held → outputs stay 0. After reset deasserts, the press is accepted `DEBOUNCE_CYCLES`+2 edges later.
- With `KEY_DEBOUNCE_REPEAT_EN`, hold the key for 30 cycles after acceptance → extra `key_press` pulses at +10, +15, +20, +25 and +30; `key_toggle` changes only once. Without the macro → a single pulse only.
